// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioning slice.
//   rep_state_t      : state encoding of the per-channel press/repeat FSM
//   *_DEF constants  : default timing in 1 kHz clock cycles (1 cycle = 1 ms)
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } rep_state_t;

  localparam int DEBOUNCE_CYC_DEF = 20;   // 20 ms stable before a level change is accepted
  localparam int HOLD_CYC_DEF     = 500;  // 500 ms hold before auto-repeat starts
  localparam int REPEAT_CYC_DEF   = 200;  // 200 ms between auto-repeat strobes
  localparam int CNT_W_DEF        = 10;   // wide enough for the largest terminal count

endpackage

// File: rtl/btn_if.sv
// Button bundle between the raw push-buttons and the watch core.
//   mode_raw, up_raw     : raw active-high buttons (asynchronous, bouncy)
//   mode_pulse, up_pulse : one-cycle strobes per accepted press / repeat tick
//   mode_level, up_level : debounced button levels
//   rep_active           : up channel is auto-repeating
// master = side that drives the buttons, slave = the conditioner.
interface btn_if;

  logic mode_raw;
  logic up_raw;
  logic mode_pulse;
  logic up_pulse;
  logic mode_level;
  logic up_level;
  logic rep_active;

  modport master (
    output mode_raw, up_raw,
    input  mode_pulse, up_pulse, mode_level, up_level, rep_active
  );

  modport slave (
    input  mode_raw, up_raw,
    output mode_pulse, up_pulse, mode_level, up_level, rep_active
  );

endinterface

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchroniser, debounce counter, registered
// press strobe and (when REPEAT_EN) hold-to-repeat FSM.
//   clk        : 1 kHz system clock
//   rst        : asynchronous active-high reset
//   raw        : raw button input
//   level      : debounced level
//   pulse      : one-cycle strobe on accepted press or repeat tick
//   rep_active : FSM is in REPEAT
module btn_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int HOLD_CYC     = HOLD_CYC_DEF,
  parameter int REPEAT_CYC   = REPEAT_CYC_DEF,
  parameter int CNT_W        = CNT_W_DEF,
  parameter bit REPEAT_EN    = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic pulse,
  output logic rep_active
);

  logic             sync1, sync2;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] rcnt, rcnt_next;
  rep_state_t       state, state_next;
  logic             pulse_next;
  logic             accept, rise, fall;

  // A level change is accepted on the DEBOUNCE_CYC-th consecutive differing sample.
  assign accept = (sync2 != level) && (cnt == CNT_W'(DEBOUNCE_CYC - 1));
  assign rise   = accept && sync2;
  assign fall   = accept && !sync2;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_next = state;
    rcnt_next  = rcnt;
    pulse_next = 1'b0;
    if (fall) begin
      // Release wins over a same-cycle hold/repeat expiry.
      state_next = IDLE;
      rcnt_next  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            pulse_next = 1'b1;
            rcnt_next  = '0;
            if (REPEAT_EN) state_next = HOLD;
          end
        end
        HOLD: begin
          if (rcnt == CNT_W'(HOLD_CYC - 1)) begin
            pulse_next = 1'b1;
            rcnt_next  = '0;
            state_next = REPEAT;
          end else begin
            rcnt_next = rcnt + CNT_W'(1);
          end
        end
        REPEAT: begin
          if (rcnt == CNT_W'(REPEAT_CYC - 1)) begin
            pulse_next = 1'b1;
            rcnt_next  = '0;
          end else begin
            rcnt_next = rcnt + CNT_W'(1);
          end
        end
        default: begin
          state_next = IDLE;
          rcnt_next  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rcnt       <= '0;
      pulse      <= 1'b0;
      rep_active <= 1'b0;
    end else begin
      state      <= state_next;
      rcnt       <= rcnt_next;
      pulse      <= pulse_next;
      rep_active <= (state_next == REPEAT);
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Conditions the mode and up push-buttons for the watch core: synchronise,
// debounce, one strobe per press, and hold-to-repeat on the up button.
//   clk_1k : 1 kHz system clock
//   rst    : asynchronous active-high reset
//   bus    : btn_if slave (raw buttons in; strobes, levels, rep_active out)
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int HOLD_CYC     = HOLD_CYC_DEF,
  parameter int REPEAT_CYC   = REPEAT_CYC_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic clk_1k,
  input  logic rst,
  btn_if.slave bus
);

  logic mode_pulse_ch;
  logic up_pulse_ch;
  logic mode_rep_unused;
  logic up_rep;

  btn_channel #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .HOLD_CYC     (HOLD_CYC),
    .REPEAT_CYC   (REPEAT_CYC),
    .CNT_W        (CNT_W),
    .REPEAT_EN    (1'b0)
  ) u_mode (
    .clk        (clk_1k),
    .rst        (rst),
    .raw        (bus.mode_raw),
    .level      (bus.mode_level),
    .pulse      (mode_pulse_ch),
    .rep_active (mode_rep_unused)
  );

  btn_channel #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .HOLD_CYC     (HOLD_CYC),
    .REPEAT_CYC   (REPEAT_CYC),
    .CNT_W        (CNT_W),
    .REPEAT_EN    (1'b1)
  ) u_up (
    .clk        (clk_1k),
    .rst        (rst),
    .raw        (bus.up_raw),
    .level      (bus.up_level),
    .pulse      (up_pulse_ch),
    .rep_active (up_rep)
  );

  // The core acts on one strobe per cycle; mode wins a collision. Both
  // strobes come straight from flops, so the mask adds no register stage.
  assign bus.mode_pulse = mode_pulse_ch;
  assign bus.up_pulse   = up_pulse_ch & ~mode_pulse_ch;
  assign bus.rep_active = up_rep;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner at default timing. Edge index 0 (E) is
// the first clock edge that samples a new raw value; strobes are logged by
// edge index and compared with hand-derived positions.
module tb_btn_conditioner;

  logic clk_1k;
  logic rst;
  int   tests;
  int   fails;

  btn_if bus ();

  btn_conditioner dut (
    .clk_1k (clk_1k),
    .rst    (rst),
    .bus    (bus)
  );

  initial clk_1k = 1'b0;
  always #5 clk_1k = ~clk_1k;

  // Observation log for the current window.
  int   idx;
  int   up_q[$];
  int   mode_q[$];
  int   both_cnt;
  int   rep_rise;
  int   mlvl_rise, mlvl_fall;
  bit   ulvl_seen;
  logic rep_prev, mlvl_prev;

  task automatic tick();
    @(posedge clk_1k);
    #1;
  endtask

  task automatic open_window();
    up_q.delete();
    mode_q.delete();
    idx       = 0;
    both_cnt  = 0;
    rep_rise  = -1;
    mlvl_rise = -1;
    mlvl_fall = -1;
    ulvl_seen = 1'b0;
    rep_prev  = bus.rep_active;
    mlvl_prev = bus.mode_level;
  endtask

  task automatic run_edges(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      if (bus.up_pulse)   up_q.push_back(idx);
      if (bus.mode_pulse) mode_q.push_back(idx);
      if (bus.up_pulse && bus.mode_pulse) both_cnt++;
      if (bus.rep_active && !rep_prev && rep_rise < 0) rep_rise = idx;
      if (bus.mode_level && !mlvl_prev && mlvl_rise < 0) mlvl_rise = idx;
      if (!bus.mode_level && mlvl_prev && mlvl_fall < 0) mlvl_fall = idx;
      if (bus.up_level) ulvl_seen = 1'b1;
      rep_prev  = bus.rep_active;
      mlvl_prev = bus.mode_level;
      idx++;
    end
  endtask

  task automatic test_reset();
    logic [4:0] outs;
    rst = 1'b1;
    bus.mode_raw = 1'b0;
    bus.up_raw   = 1'b0;
    repeat (3) tick();
    outs = {bus.mode_pulse, bus.up_pulse, bus.mode_level, bus.up_level, bus.rep_active};
    tests++;
    if (outs !== 5'b0) begin
      fails++;
      $display("FAIL reset_outputs: got %b, expected 00000", outs);
    end
    rst = 1'b0;
    open_window();
    run_edges(100);
    outs = {bus.mode_pulse, bus.up_pulse, bus.mode_level, bus.up_level, bus.rep_active};
    tests++;
    if (outs !== 5'b0) begin
      fails++;
      $display("FAIL idle_outputs: got %b, expected 00000", outs);
    end
    tests++;
    if (up_q.size() + mode_q.size() != 0 || ulvl_seen || mlvl_rise >= 0 || rep_rise >= 0) begin
      fails++;
      $display("FAIL idle_activity: pulses=%0d up_level_seen=%0b, expected none",
               up_q.size() + mode_q.size(), ulvl_seen);
    end
  endtask

  task automatic test_mode_press();
    open_window();
    bus.mode_raw = 1'b1;
    run_edges(60);
    bus.mode_raw = 1'b0;  // edge 60 is the first to sample low
    run_edges(40);
    tests++;
    if (mode_q.size() != 1 || mode_q[0] != 21) begin
      fails++;
      $display("FAIL mode_pulse: count=%0d first=%0d, expected one at 21",
               mode_q.size(), (mode_q.size() > 0) ? mode_q[0] : -1);
    end
    tests++;
    if (mlvl_rise != 21 || mlvl_fall != 81) begin
      fails++;
      $display("FAIL mode_level: rise=%0d fall=%0d, expected 21 and 81", mlvl_rise, mlvl_fall);
    end
    tests++;
    if (up_q.size() != 0 || ulvl_seen) begin
      fails++;
      $display("FAIL mode_crosstalk: up pulses=%0d up_level_seen=%0b, expected 0", up_q.size(), ulvl_seen);
    end
  endtask

  task automatic test_bounce();
    open_window();
    // 15 cycles of bounce toggling every 3 cycles, then stable high from edge 15.
    for (int s = 0; s < 5; s++) begin
      bus.up_raw = s[0];
      run_edges(3);
    end
    bus.up_raw = 1'b1;
    run_edges(50);
    tests++;
    if (bus.up_level !== 1'b1) begin
      fails++;
      $display("FAIL bounce_level: got %b, expected 1", bus.up_level);
    end
    bus.up_raw = 1'b0;
    run_edges(30);
    tests++;
    if (up_q.size() != 1 || up_q[0] != 36) begin
      fails++;
      $display("FAIL bounce_pulse: count=%0d first=%0d, expected one at 36",
               up_q.size(), (up_q.size() > 0) ? up_q[0] : -1);
    end
  endtask

  task automatic test_repeat();
    int exp_edges[5] = '{21, 521, 721, 921, 1121};
    int got;
    open_window();
    bus.up_raw = 1'b1;
    run_edges(1200);
    tests++;
    if (up_q.size() != 5) begin
      fails++;
      $display("FAIL repeat_count: got %0d pulses, expected 5", up_q.size());
    end
    for (int i = 0; i < 5; i++) begin
      got = (i < up_q.size()) ? up_q[i] : -1;
      tests++;
      if (got != exp_edges[i]) begin
        fails++;
        $display("FAIL repeat_edge[%0d]: got %0d, expected %0d", i, got, exp_edges[i]);
      end
    end
    tests++;
    if (rep_rise != 521) begin
      fails++;
      $display("FAIL rep_active_rise: got %0d, expected 521", rep_rise);
    end
    bus.up_raw = 1'b0;
    run_edges(30);
    tests++;
    if (bus.rep_active !== 1'b0 || bus.up_level !== 1'b0) begin
      fails++;
      $display("FAIL repeat_release: rep_active=%b up_level=%b, expected 0 0", bus.rep_active, bus.up_level);
    end
  endtask

  task automatic test_glitch();
    open_window();
    bus.up_raw = 1'b1;
    run_edges(19);
    bus.up_raw = 1'b0;
    run_edges(40);
    tests++;
    if (up_q.size() != 0 || ulvl_seen) begin
      fails++;
      $display("FAIL glitch19: pulses=%0d up_level_seen=%0b, expected 0 0", up_q.size(), ulvl_seen);
    end
    open_window();
    bus.up_raw = 1'b1;
    run_edges(20);
    bus.up_raw = 1'b0;
    run_edges(60);
    tests++;
    if (up_q.size() != 1 || up_q[0] != 21) begin
      fails++;
      $display("FAIL glitch20: count=%0d first=%0d, expected one at 21",
               up_q.size(), (up_q.size() > 0) ? up_q[0] : -1);
    end
  endtask

  task automatic test_simultaneous();
    open_window();
    bus.mode_raw = 1'b1;
    bus.up_raw   = 1'b1;
    run_edges(600);
    tests++;
    if (mode_q.size() != 1 || mode_q[0] != 21) begin
      fails++;
      $display("FAIL simul_mode: count=%0d first=%0d, expected one at 21",
               mode_q.size(), (mode_q.size() > 0) ? mode_q[0] : -1);
    end
    // The press strobe at 21 is masked; HOLD still runs and expires at 521.
    tests++;
    if (up_q.size() != 1 || up_q[0] != 521) begin
      fails++;
      $display("FAIL simul_up: count=%0d first=%0d, expected one at 521",
               up_q.size(), (up_q.size() > 0) ? up_q[0] : -1);
    end
    tests++;
    if (both_cnt != 0 || rep_rise != 521) begin
      fails++;
      $display("FAIL simul_overlap: overlaps=%0d rep_rise=%0d, expected 0 and 521", both_cnt, rep_rise);
    end
    bus.mode_raw = 1'b0;
    bus.up_raw   = 1'b0;
    run_edges(30);
  endtask

  task automatic test_reset_mid_press();
    logic [4:0] outs;
    int         bad;
    open_window();
    bus.up_raw = 1'b1;
    run_edges(300);
    tests++;
    if (up_q.size() != 1 || up_q[0] != 21) begin
      fails++;
      $display("FAIL pre_reset_pulse: count=%0d, expected one at 21", up_q.size());
    end
    rst = 1'b1;
    bad = 0;
    #1;
    outs = {bus.mode_pulse, bus.up_pulse, bus.mode_level, bus.up_level, bus.rep_active};
    if (outs !== 5'b0) bad++;
    repeat (3) begin
      tick();
      outs = {bus.mode_pulse, bus.up_pulse, bus.mode_level, bus.up_level, bus.rep_active};
      if (outs !== 5'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL reset_mid_press_outputs: %0d samples nonzero, expected 0", bad);
    end
    rst = 1'b0;
    open_window();  // index 0 is the first post-reset edge
    run_edges(600);
    tests++;
    if (up_q.size() != 2 || up_q[0] != 21 || up_q[1] != 521) begin
      fails++;
      $display("FAIL post_reset_pulses: count=%0d first=%0d, expected 21 and 521",
               up_q.size(), (up_q.size() > 0) ? up_q[0] : -1);
    end
    tests++;
    if (rep_rise != 521) begin
      fails++;
      $display("FAIL post_reset_rep: got %0d, expected 521", rep_rise);
    end
    bus.up_raw = 1'b0;
    run_edges(40);
  endtask

  initial begin
    #(500_000);
    $display("FAIL timeout: bench did not complete within time limit");
    $fatal(1);
  end

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_mode_press();
    test_bounce();
    test_repeat();
    test_glitch();
    test_simultaneous();
    test_reset_mid_press();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
